w_cpu_io_bridge: RTL

//  CPU-side bridge for the west-edge CPU IO tile. Accepts 16-bit operand words from the CPU and streams them

---
 rtl/w_cpu_io_bridge.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/w_cpu_io_bridge.sv
// CPU-side bridge for the west-edge CPU IO tile: serializes 16-bit operands into 4-bit fabric beats and
// packs 8-bit result beats into 32-bit CPU words. Optional macro CPU_IO_BRIDGE_OVF_CNT_EN adds res_drop_cnt.
module w_cpu_io_bridge #(
    parameter int OP_DEPTH  = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic        UserCLK,
    input  logic        resetn,
    input  logic [15:0] op_data,
    input  logic        op_valid,
    output logic        op_ready,
    output logic [3:0]  OPA_O,
    output logic [3:0]  OPB_O,
    input  logic [3:0]  RES0_I,
    input  logic [3:0]  RES1_I,
    input  logic [3:0]  RES2_I,
    output logic [31:0] res_data,
    output logic [2:0]  res_bytes,
    output logic [1:0]  res_tag,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_ovf,
    input  logic        res_ovf_clr
`ifdef CPU_IO_BRIDGE_OVF_CNT_EN
    ,
    output logic [7:0]  res_drop_cnt
`endif
);

    localparam int OPW = $clog2(OP_DEPTH);
    localparam int RSW = $clog2(RES_DEPTH);
    localparam logic [OPW:0] OP_FULL  = OP_DEPTH[OPW:0];
    localparam logic [RSW:0] RES_FULL = RES_DEPTH[RSW:0];

    // ---------------- operand FIFO ----------------
    logic [15:0]    op_mem [OP_DEPTH];
    logic [OPW-1:0] op_wr, op_rd;
    logic [OPW:0]   op_cnt;
    logic           op_empty, op_full, op_push, op_pop;

    assign op_empty = (op_cnt == '0);
    assign op_full  = (op_cnt == OP_FULL);
    // A full FIFO still accepts a word in the cycle the serializer pops; op_pop never depends on op_valid.
    assign op_ready = !op_full || op_pop;
    assign op_push  = op_valid && op_ready;

    always_ff @(posedge UserCLK) begin
        if (op_push) op_mem[op_wr] <= op_data;
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            op_wr  <= '0;
            op_rd  <= '0;
            op_cnt <= '0;
        end else begin
            if (op_push) op_wr <= op_wr + OPW'(1);
            if (op_pop)  op_rd <= op_rd + OPW'(1);
            case ({op_push, op_pop})
                2'b10:   op_cnt <= op_cnt + (OPW+1)'(1);
                2'b01:   op_cnt <= op_cnt - (OPW+1)'(1);
                default: op_cnt <= op_cnt;
            endcase
        end
    end

    // ---------------- serializer FSM ----------------
    typedef enum logic {S_IDLE, S_SEND} ser_state_t;
    ser_state_t  state, state_n;
    logic [1:0]  idx, idx_n;
    logic [15:0] word, word_n;
    logic [3:0]  opa_n, opb_n;
    logic        load;

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            idx   <= 2'd0;
            word  <= 16'd0;
            OPA_O <= 4'd0;
            OPB_O <= 4'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            word  <= word_n;
            OPA_O <= opa_n;
            OPB_O <= opb_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        word_n  = word;
        opa_n   = 4'd0;
        opb_n   = 4'd0;
        load    = 1'b0;
        op_pop  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!op_empty) load = 1'b1;
            end
            S_SEND: begin
                if (idx == 2'd3) begin
                    if (!op_empty) load = 1'b1;
                    else           state_n = S_IDLE;
                end else begin
                    idx_n = idx + 2'd1;
                    opa_n = word[{idx_n, 2'b00} +: 4];
                    opb_n = {1'b1, idx_n == 2'd3, idx_n};
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Loading from beat 3 chains words with no idle cycle between them.
        if (load) begin
            op_pop  = 1'b1;
            word_n  = op_mem[op_rd];
            idx_n   = 2'd0;
            state_n = S_SEND;
            opa_n   = op_mem[op_rd][3:0];
            opb_n   = 4'b1000;
        end
    end

    // ---------------- result packer ----------------
    logic        beat_valid, beat_last, close;
    logic [1:0]  beat_tag, lane, acc_tag, cur_tag;
    logic [7:0]  beat_byte;
    logic [31:0] acc, merged;
    logic        pend_valid;
    logic [31:0] pend_data;
    logic [2:0]  pend_bytes;
    logic [1:0]  pend_tag;

    assign beat_valid = RES2_I[3];
    assign beat_last  = RES2_I[2];
    assign beat_tag   = RES2_I[1:0];
    assign beat_byte  = {RES1_I, RES0_I};
    // Lane 0 starts from zero so short words carry zeros in their unused lanes.
    assign merged  = ((lane == 2'd0) ? 32'd0 : acc) | (32'(beat_byte) << {lane, 3'b000});
    assign cur_tag = (lane == 2'd0) ? beat_tag : acc_tag;
    assign close   = beat_valid && ((lane == 2'd3) || beat_last);

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            lane       <= 2'd0;
            acc        <= 32'd0;
            acc_tag    <= 2'd0;
            pend_valid <= 1'b0;
            pend_data  <= 32'd0;
            pend_bytes <= 3'd0;
            pend_tag   <= 2'd0;
        end else begin
            pend_valid <= close;
            if (close) begin
                pend_data  <= merged;
                pend_bytes <= {1'b0, lane} + 3'd1;
                pend_tag   <= cur_tag;
            end
            if (beat_valid) begin
                lane    <= close ? 2'd0 : lane + 2'd1;
                acc     <= merged;
                acc_tag <= cur_tag;
            end
        end
    end

    // ---------------- result FIFO (first-word fall-through) ----------------
    logic [36:0]    res_mem [RES_DEPTH];
    logic [RSW-1:0] res_wr, res_rd;
    logic [RSW:0]   res_cnt;
    logic           res_empty, res_full, res_pop, res_wr_en, drop;
    logic [36:0]    head;

    assign res_empty = (res_cnt == '0);
    assign res_full  = (res_cnt == RES_FULL);
    assign res_pop   = res_ready && !res_empty;
    assign res_wr_en = pend_valid && (!res_full || res_pop);
    assign drop      = pend_valid && res_full && !res_pop;
    assign head      = res_mem[res_rd];

    assign res_valid = !res_empty;
    assign res_data  = res_empty ? 32'd0 : head[31:0];
    assign res_bytes = res_empty ? 3'd0  : head[34:32];
    assign res_tag   = res_empty ? 2'd0  : head[36:35];

    always_ff @(posedge UserCLK) begin
        if (res_wr_en) res_mem[res_wr] <= {pend_tag, pend_bytes, pend_data};
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            res_wr  <= '0;
            res_rd  <= '0;
            res_cnt <= '0;
            res_ovf <= 1'b0;
        end else begin
            if (res_wr_en) res_wr <= res_wr + RSW'(1);
            if (res_pop)   res_rd <= res_rd + RSW'(1);
            case ({res_wr_en, res_pop})
                2'b10:   res_cnt <= res_cnt + (RSW+1)'(1);
                2'b01:   res_cnt <= res_cnt - (RSW+1)'(1);
                default: res_cnt <= res_cnt;
            endcase
            // A fresh drop outranks a clear in the same cycle.
            if (drop)             res_ovf <= 1'b1;
            else if (res_ovf_clr) res_ovf <= 1'b0;
        end
    end

`ifdef CPU_IO_BRIDGE_OVF_CNT_EN
    logic [7:0] cnt_base;
    assign cnt_base = res_ovf_clr ? 8'd0 : res_drop_cnt;

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn)                          res_drop_cnt <= 8'd0;
        else if (drop && cnt_base != 8'd255)  res_drop_cnt <= cnt_base + 8'd1;
        else if (!drop)                       res_drop_cnt <= cnt_base;
    end
`endif

endmodule
